ram_fifo_ctrl: RTL and testbench
================================

# ram_fifo_ctrl

Single-clock first-word-fall-through FIFO controller that drives a TureDualPortRAM instance: port A is the write port and port B the read port, with 1-cycle read latency. A 2-entry prefetch buffer hides the RAM latency, so the pop side sustains one word per cycle with a registered valid/ready handshake. It sits in front of RAM-backed queues such as instruction buffers and store queues, and is the only agent that addresses the RAM.

## Interface
Parameters:
- DATA_DEPTH, 256, RAM entries; power of two, ≥ 2.
- DATA_WIDTH, 32, word width; the RAM is instantiated with BYTE_WRITE_WIDTH = DATA_WIDTH, so the write enable is 1 bit.
- ADDR_WIDTH (localparam), $clog2(DATA_DEPTH).
- CNT_WIDTH (localparam), $clog2(DATA_DEPTH+3).

Ports:
- clk  in  1  clock; the RAM's clk_a is tied to it (common_clock).
- rst  in  1  synchronous, active-high reset. The integrator ties the RAM's rsta_n/rstb_n to ~rst.
- push_valid_i  in  1  write request.
- push_ready_o  out  1  write accepted when valid&ready.
- push_data_i  in  DATA_WIDTH  write data.
- pop_valid_o  out  1  head word present.
- pop_ready_i  in  1  consumer takes head when valid&ready.
- pop_data_o  out  DATA_WIDTH  head word; stable while valid and not ready.
- count_o  out  CNT_WIDTH  total words held.
- ram_en_a_o, ram_we_a_o  out  1  port A enable and write enable (equal).
- ram_addr_a_o  out  ADDR_WIDTH  write pointer.
- ram_data_a_o  out  DATA_WIDTH  equals push_data_i.
- ram_en_b_o  out  1  read issue; the RAM's we_b_i is tied 0.
- ram_addr_b_o  out  ADDR_WIDTH  read pointer.
- ram_data_b_i  in  DATA_WIDTH  RAM port B output, valid the cycle after ram_en_b_o.

## Operation
- State: wr_ptr, rd_ptr (ADDR_WIDTH, wrap naturally); ram_cnt (0..DATA_DEPTH); inflight (1 bit); buf_cnt (0..2) with head and skid registers.
- Push fire is push_valid_i & push_ready_o. It asserts ram_en_a_o/ram_we_a_o at wr_ptr, then increments wr_ptr.
- push_ready_o = !rst && ram_cnt != DATA_DEPTH. The prefetch buffer never back-pressures push.
- pop_fire = pop_valid_o & pop_ready_i.
- Read issue: ram_en_b_o = ram_cnt != 0 && (buf_cnt + inflight − pop_fire) < 2. On issue, rd_ptr increments, ram_cnt decrements, and inflight is set for the next cycle.
- ram_cnt next = ram_cnt + push_fire − issue. Simultaneous push and issue leaves it unchanged.
- An address collision is impossible: a read only targets entries written in an earlier cycle, and a write only occurs when not full. WRITE_MODE is therefore irrelevant.
- Capture: when inflight is set, ram_data_b_i enters the buffer this cycle. Buffer update order:
  - Pop removes head; skid moves to head.
  - The captured word then goes to the first free slot.
  - With buf_cnt=2, a simultaneous pop and capture gives head←skid, skid←new.
- pop_valid_o = buf_cnt != 0. pop_data_o = head.
- count_o = ram_cnt + inflight + buf_cnt. Maximum is DATA_DEPTH+2 (RAM full, buffer full, nothing in flight).
- Reset clears ptrs, ram_cnt, inflight and buf_cnt. A read in flight at reset is discarded: its return cycle sees inflight=0. Head/skid data contents are don't-care.

## Timing
- Reset values: push_ready_o 0 while rst is high, 1 in the first cycle after; pop_valid_o 0; count_o 0; ram_en_a_o/ram_we_a_o/ram_en_b_o 0; ram_addr_a_o/ram_addr_b_o 0; pop_data_o 0.
- Empty-FIFO latency: push accepted in cycle 0, read issued in cycle 1, captured in cycle 2, pop_valid_o=1 in cycle 3.
- Steady-state throughput: 1 push and 1 pop per cycle, with no bubbles once buf_cnt ≥ 1.
- pop_valid_o, pop_data_o and count_o are register outputs.
- push_ready_o and ram_en_b_o are combinational from registers plus pop_ready_i. No path runs from push_valid_i to push_ready_o.
- pop_valid_o never deasserts without a pop_fire, and pop_data_o is held while stalled.
- Order is preserved across RAM wrap (wr_ptr DATA_DEPTH−1→0).

## Test plan
- Reset/empty: assert rst for 3 cycles with push_valid_i=1 → nothing written; push_ready_o=0, then 1 in the first cycle after release; count_o=0; pop_valid_o=0.
- Latency: single push of 0xA5A5_0001 at cycle 0 with pop_ready_i=1 → ram_en_b_o at cycle 1, pop_valid_o with 0xA5A5_0001 at cycle 3, count_o back to 0 at cycle 4.
- Fill: DATA_DEPTH=4, pop_ready_i=0, push 0..9 → 6 accepted (values 0..5); push_ready_o=0 thereafter; count_o=6; pop_data_o=0 held stable.
- Streaming with wrap: DATA_DEPTH=4, push and pop every cycle for 20 words 0..19 → outputs 0..19 in order, one per cycle after fill; no gap and no duplicate.
- Random back-pressure: random push_valid_i/pop_ready_i at 50% for 1000 cycles → scoreboard matches; count_o equals pushes − pops each cycle; count_o never exceeds DATA_DEPTH+2.
- Mid-operation reset: assert rst the cycle after a read issue with buf_cnt=1 → next cycle pop_valid_o=0, count_o=0; the stale ram_data_b_i is not captured; a subsequent push of 0x7 pops 0x7 first.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving a true-dual-port RAM
// (port A writes, port B reads with 1-cycle latency) plus a 2-entry prefetch buffer.
module ram_fifo_ctrl #(
  parameter int DATA_DEPTH = 256,
  parameter int DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH),
  localparam int CNT_WIDTH  = $clog2(DATA_DEPTH + 3)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic                  pop_valid_o,
  input  logic                  pop_ready_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  ram_en_a_o,
  output logic                  ram_we_a_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_a_o,
  output logic [DATA_WIDTH-1:0] ram_data_a_o,
  output logic                  ram_en_b_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_b_o,
  input  logic [DATA_WIDTH-1:0] ram_data_b_i
);

  localparam logic [ADDR_WIDTH:0] RAM_FULL = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  inflight;
  logic [1:0]            buf_cnt, buf_cnt_n;
  logic [DATA_WIDTH-1:0] head, skid, head_n, skid_n;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  pop_valid_q;
  logic                  push_fire, pop_fire, issue;
  logic [2:0]            occ;

  assign push_ready_o = !rst && (ram_cnt != RAM_FULL);
  assign push_fire    = push_valid_i & push_ready_o;
  assign pop_fire     = pop_valid_q & pop_ready_i;

  // Words that will occupy the buffer next cycle if nothing new is issued
  assign occ   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop_fire};
  assign issue = !rst && (ram_cnt != '0) && (occ < 3'd2);

  always_comb begin
    head_n    = head;
    skid_n    = skid;
    buf_cnt_n = buf_cnt;
    if (pop_fire) begin
      head_n    = skid;
      buf_cnt_n = buf_cnt - 2'd1;
    end
    if (inflight) begin
      if (buf_cnt_n == 2'd0) head_n = ram_data_b_i;
      else                   skid_n = ram_data_b_i;
      buf_cnt_n = buf_cnt_n + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      inflight    <= 1'b0;
      buf_cnt     <= 2'd0;
      head        <= '0;
      skid        <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (issue)     rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push_fire, issue})
        2'b10:   ram_cnt <= ram_cnt + (ADDR_WIDTH + 1)'(1);
        2'b01:   ram_cnt <= ram_cnt - (ADDR_WIDTH + 1)'(1);
        default: ram_cnt <= ram_cnt;
      endcase
      case ({push_fire, pop_fire})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
      inflight    <= issue;
      buf_cnt     <= buf_cnt_n;
      head        <= head_n;
      skid        <= skid_n;
      pop_valid_q <= (buf_cnt_n != 2'd0);
    end
  end

  assign pop_valid_o  = pop_valid_q;
  assign pop_data_o   = head;
  assign count_o      = count_q;
  assign ram_en_a_o   = push_fire;
  assign ram_we_a_o   = push_fire;
  assign ram_addr_a_o = wr_ptr;
  assign ram_data_a_o = push_data_i;
  assign ram_en_b_o   = issue;
  assign ram_addr_b_o = rd_ptr;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with DATA_DEPTH=4 and a behavioural 1-cycle-latency RAM.
module tb_ram_fifo_ctrl;
  localparam int DEPTH = 4;
  localparam int W     = 32;
  localparam int AW    = 2;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_valid_i, push_ready_o, pop_valid_o, pop_ready_i;
  logic [W-1:0]  push_data_i, pop_data_o, ram_data_a_o;
  logic [W-1:0]  ram_data_b_i;
  logic [CW-1:0] count_o;
  logic          ram_en_a_o, ram_we_a_o, ram_en_b_o;
  logic [AW-1:0] ram_addr_a_o, ram_addr_b_o;
  logic [W-1:0]  mem [DEPTH];

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_DEPTH(DEPTH), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_data_i(push_data_i),
    .pop_valid_o(pop_valid_o), .pop_ready_i(pop_ready_i), .pop_data_o(pop_data_o),
    .count_o(count_o),
    .ram_en_a_o(ram_en_a_o), .ram_we_a_o(ram_we_a_o), .ram_addr_a_o(ram_addr_a_o),
    .ram_data_a_o(ram_data_a_o), .ram_en_b_o(ram_en_b_o), .ram_addr_b_o(ram_addr_b_o),
    .ram_data_b_i(ram_data_b_i)
  );

  always @(posedge clk) begin
    if (ram_en_a_o && ram_we_a_o) mem[ram_addr_a_o] <= ram_data_a_o;
    if (ram_en_b_o) ram_data_b_i <= mem[ram_addr_b_o];
  end

  typedef struct {
    logic        pv;
    logic [31:0] pd;
    logic        pr;
    logic        e_pready;
    logic        e_ena;
    logic        e_enb;
    logic        e_pvalid;
    logic [31:0] e_pdata;
    logic [2:0]  e_cnt;
  } vec_t;

  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] sb [$];
  int          exp_cnt = 0;
  int          cyc = 0;
  int          pop_cnt = 0;
  int          first_pop = 0;
  int          last_pop = 0;
  int          accepted = 0;
  logic        last_push;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then check at the falling edge; caller ends with tick().
  task automatic step(input logic pv, input logic [31:0] pd, input logic pr);
    logic do_push, do_pop;
    push_valid_i = pv;
    push_data_i  = pd;
    pop_ready_i  = pr;
    @(negedge clk);
    check("count", 32'(count_o), 32'(exp_cnt));
    check("count_max", 32'(count_o <= CW'(DEPTH + 2)), 32'd1);
    if (hold_v) begin
      check("pop_valid_held", 32'(pop_valid_o), 32'd1);
      if (pop_valid_o) check("pop_data_held", pop_data_o, hold_d);
    end
    do_pop  = pop_valid_o && pr;
    do_push = pv && push_ready_o;
    if (do_pop) begin
      pop_cnt++;
      if (pop_cnt == 1) first_pop = cyc;
      last_pop = cyc;
      if (sb.size() == 0) check("pop_underflow", 32'd1, 32'd0);
      else check("pop_data", pop_data_o, sb.pop_front());
    end
    if (do_push) sb.push_back(pd);
    exp_cnt  += int'(do_push) - int'(do_pop);
    last_push = do_push;
    hold_v    = pop_valid_o && !pr;
    hold_d    = pop_data_o;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 60; k++) begin
      if (exp_cnt == 0 && count_o == '0) break;
      step(1'b0, 32'h0, 1'b1);
      tick();
    end
    check("drain_timeout", 32'(k < 60), 32'd1);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t lat [5];
    int   k;
    lat[0] = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         3'd0};
    lat[1] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         3'd1};
    lat[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         3'd1};
    lat[3] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 3'd1};
    lat[4] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         3'd0};

    // Reset held with push_valid_i high: nothing may be written
    rst = 1'b1;
    push_valid_i = 1'b1;
    push_data_i  = 32'hDEAD;
    pop_ready_i  = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'hDEAD, 1'b0);
      check("rst_push_ready", 32'(push_ready_o), 32'd0);
      check("rst_ram_en_a", 32'(ram_en_a_o), 32'd0);
      check("rst_ram_en_b", 32'(ram_en_b_o), 32'd0);
      check("rst_pop_valid", 32'(pop_valid_o), 32'd0);
      tick();
    end
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    check("post_rst_push_ready", 32'(push_ready_o), 32'd1);
    check("post_rst_pop_data", pop_data_o, 32'h0);
    check("post_rst_addr_a", 32'(ram_addr_a_o), 32'd0);
    tick();

    // Empty-FIFO latency, table driven
    for (int i = 0; i < 5; i++) begin
      step(lat[i].pv, lat[i].pd, lat[i].pr);
      check("lat_push_ready", 32'(push_ready_o), 32'(lat[i].e_pready));
      check("lat_ram_en_a", 32'(ram_en_a_o), 32'(lat[i].e_ena));
      check("lat_ram_en_b", 32'(ram_en_b_o), 32'(lat[i].e_enb));
      check("lat_pop_valid", 32'(pop_valid_o), 32'(lat[i].e_pvalid));
      if (lat[i].e_pvalid) check("lat_pop_data", pop_data_o, lat[i].e_pdata);
      check("lat_count", 32'(count_o), 32'(lat[i].e_cnt));
      tick();
    end

    // Fill with no pops: RAM holds 4, prefetch buffer 2
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'(i), 1'b0);
      if (last_push) accepted++;
      tick();
    end
    check("fill_accepted", 32'(accepted), 32'd6);
    step(1'b0, 32'h0, 1'b0);
    check("fill_push_ready", 32'(push_ready_o), 32'd0);
    check("fill_count", 32'(count_o), 32'd6);
    check("fill_pop_data", pop_data_o, 32'h0);
    tick();
    drain();

    // Streaming through RAM wrap: one pop per cycle without gaps
    pop_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'(i), 1'b1);
      tick();
    end
    drain();
    check("stream_pops", 32'(pop_cnt), 32'd20);
    check("stream_span", 32'(last_pop - first_pop), 32'd19);

    // Random back-pressure
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      tick();
    end
    drain();

    // Reset while a read is in flight with one word buffered
    step(1'b1, 32'h11, 1'b0);
    tick();
    for (k = 0; k < 10; k++) begin
      step(1'b0, 32'h0, 1'b0);
      if (pop_valid_o) break;
      tick();
    end
    check("mid_wait_timeout", 32'(k < 10), 32'd1);
    tick();
    step(1'b1, 32'h22, 1'b0);
    tick();
    step(1'b0, 32'h0, 1'b0);
    check("mid_issue", 32'(ram_en_b_o), 32'd1);
    tick();
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    tick();
    rst = 1'b0;
    sb.delete();
    exp_cnt = 0;
    hold_v  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b0);
      check("mid_pop_valid", 32'(pop_valid_o), 32'd0);
      tick();
    end
    pop_cnt = 0;
    step(1'b1, 32'h7, 1'b1);
    tick();
    drain();
    check("mid_pop_cnt", 32'(pop_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
